// File: rtl/microsequencer.sv
// ============================================================================
// microsequencer : control-store next-address generator with dispatch tables,
//                  stall hold path and a sticky invalid-dispatch trap.
// Revision 1.0
// ============================================================================
`default_nettype none

module microsequencer #(
  parameter int unsigned AW         = 5,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned TRAP_ADDR  = 31,
  parameter int unsigned OPW        = 4,
  parameter int unsigned MDW        = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [24:0]    controlword,
  input  logic           stall,
  input  logic           alu_zero,
  input  logic [OPW-1:0] ir_opcode,
  input  logic [MDW-1:0] ir_mode,
  input  logic           tbl_we,
  input  logic           tbl_sel,
  input  logic [OPW-1:0] tbl_idx,
  input  logic [AW-1:0]  tbl_data,
  output logic [AW-1:0]  address,
  output logic [AW-1:0]  upc,
  output logic           trap
);

  localparam int unsigned MODE_DEPTH = 1 << MDW;
  localparam int unsigned OP_DEPTH   = 1 << OPW;

  localparam logic [1:0] NS_SEQ  = 2'b00;
  localparam logic [1:0] NS_MODE = 2'b01;
  localparam logic [1:0] NS_OP   = 2'b10;
  localparam logic [1:0] NS_ZERO = 2'b11;

  localparam logic [AW-1:0] START_A = AW'(START_ADDR);
  localparam logic [AW-1:0] TRAP_A  = AW'(TRAP_ADDR);

  logic [1:0]    nssel;
  logic [AW-1:0] dbin;
  logic          unused_cw;

  assign nssel     = controlword[6:5];
  assign dbin      = controlword[AW-1:0];
  assign unused_cw = ^controlword[24:7];

  logic [AW-1:0]         mode_data  [MODE_DEPTH];
  logic [AW-1:0]         op_data    [OP_DEPTH];
  logic [MODE_DEPTH-1:0] mode_valid;
  logic [OP_DEPTH-1:0]   op_valid;

  logic dispatch_bad;

  // Reset overrides everything so the control store fetches the start word
  // while reset is still asserted.
  always_comb begin
    address      = START_A;
    dispatch_bad = 1'b0;
    if (!reset) begin
      if (stall) begin
        address = upc;
      end else begin
        case (nssel)
          NS_SEQ: address = dbin;
          NS_MODE: begin
            if (mode_valid[ir_mode]) begin
              address = mode_data[ir_mode];
            end else begin
              address      = TRAP_A;
              dispatch_bad = 1'b1;
            end
          end
          NS_OP: begin
            if (op_valid[ir_opcode]) begin
              address = op_data[ir_opcode];
            end else begin
              address      = TRAP_A;
              dispatch_bad = 1'b1;
            end
          end
          NS_ZERO: address = {dbin[AW-1:1], dbin[0] | alu_zero};
          default: address = dbin;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      upc        <= START_A;
      trap       <= 1'b0;
      mode_valid <= '0;
      op_valid   <= '0;
    end else begin
      upc <= address;
      if (dispatch_bad) begin
        trap <= 1'b1;
      end
      if (tbl_we) begin
        if (tbl_sel) begin
          op_valid[tbl_idx] <= 1'b1;
        end else begin
          mode_valid[tbl_idx[MDW-1:0]] <= 1'b1;
        end
      end
    end
  end

  // Entry payloads need no reset; the valid bits gate every use.
  always_ff @(posedge clock) begin
    if (!reset && tbl_we) begin
      if (tbl_sel) begin
        op_data[tbl_idx] <= tbl_data;
      end else begin
        mode_data[tbl_idx[MDW-1:0]] <= tbl_data;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_microsequencer.sv
// ============================================================================
// tb_microsequencer : directed and randomized checks against a table model.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_microsequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [24:0] controlword;
  logic        stall;
  logic        alu_zero;
  logic [3:0]  ir_opcode;
  logic [2:0]  ir_mode;
  logic        tbl_we;
  logic        tbl_sel;
  logic [3:0]  tbl_idx;
  logic [4:0]  tbl_data;
  logic [4:0]  address;
  logic [4:0]  upc;
  logic        trap;

  microsequencer dut (
    .clock       (clock),
    .reset       (reset),
    .controlword (controlword),
    .stall       (stall),
    .alu_zero    (alu_zero),
    .ir_opcode   (ir_opcode),
    .ir_mode     (ir_mode),
    .tbl_we      (tbl_we),
    .tbl_sel     (tbl_sel),
    .tbl_idx     (tbl_idx),
    .tbl_data    (tbl_data),
    .address     (address),
    .upc         (upc),
    .trap        (trap)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference state: what the sequencer should remember between cycles.
  int m_upc;
  bit m_trap;
  int m_mode [8];
  int m_op   [16];
  bit m_mode_ok [8];
  bit m_op_ok   [16];

  function automatic int model_addr(input bit rst, input int ns, input int db,
                                    input bit stl, input bit z, input int op, input int md);
    if (rst) return 0;
    if (stl) return m_upc;
    case (ns)
      0: return db;
      1: return m_mode_ok[md] ? m_mode[md] : 31;
      2: return m_op_ok[op] ? m_op[op] : 31;
      default: return (z && (db % 2 == 0)) ? db + 1 : db;
    endcase
  endfunction

  // One clock: drive at negedge, check address before the edge, then
  // advance the model and check registered outputs after the edge.
  task automatic cycle(input bit rst, input int ns, input int db, input bit stl,
                       input bit z, input int op, input int md, input bit we,
                       input bit sel, input int idx, input int dat, input int exp_a);
    int ea;
    reset       = rst;
    controlword = {18'($urandom), 2'(ns), 5'(db)};
    stall       = stl;
    alu_zero    = z;
    ir_opcode   = 4'(op);
    ir_mode     = 3'(md);
    tbl_we      = we;
    tbl_sel     = sel;
    tbl_idx     = 4'(idx);
    tbl_data    = 5'(dat);
    #2;
    ea = model_addr(rst, ns, db, stl, z, op, md);
    check("address", 32'(address), 32'(ea));
    if (exp_a >= 0) check("spec_address", 32'(address), 32'(exp_a));
    @(posedge clock);
    if (rst) begin
      m_upc  = 0;
      m_trap = 0;
      for (int i = 0; i < 8; i++)  m_mode_ok[i] = 0;
      for (int i = 0; i < 16; i++) m_op_ok[i]   = 0;
    end else begin
      m_upc = ea;
      if (!stl && ea == 31 && ((ns == 1 && !m_mode_ok[md]) || (ns == 2 && !m_op_ok[op])))
        m_trap = 1;
      if (we) begin
        if (sel) begin
          m_op[idx]    = dat;
          m_op_ok[idx] = 1;
        end else begin
          m_mode[idx % 8]    = dat;
          m_mode_ok[idx % 8] = 1;
        end
      end
    end
    #1;
    check("upc", 32'(upc), 32'(m_upc));
    check("trap", 32'(trap), 32'(m_trap));
    @(negedge clock);
  endtask

  initial begin
    @(negedge clock);
    // Reset and first unconditional step.
    cycle(1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 2, 9, 1, 1, 9, 1, 0, 0, 0, 0, 0);
    check("reset_upc", 32'(upc), 32'd0);
    check("reset_trap", 32'(trap), 32'd0);
    cycle(0, 0, 23, 0, 0, 0, 0, 0, 0, 0, 0, 23);

    // Table writes, then mode and opcode dispatch.
    cycle(0, 0, 1, 0, 0, 0, 0, 1, 0, 2, 5, 1);
    cycle(0, 0, 2, 0, 0, 0, 0, 1, 1, 3, 12, 2);
    cycle(0, 1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 5);
    cycle(0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 12);

    // Zero branch.
    cycle(0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    cycle(0, 3, 6, 0, 1, 0, 0, 0, 0, 0, 0, 7);
    check("trap_clear_before", 32'(trap), 32'd0);

    // Invalid dispatch traps and stays set.
    cycle(0, 2, 0, 0, 0, 9, 0, 0, 0, 0, 0, 31);
    check("trap_set", 32'(trap), 32'd1);
    cycle(0, 0, 14, 0, 0, 0, 0, 0, 0, 0, 0, 14);

    // Stall holds upc for three cycles; a stalled invalid dispatch is ignored.
    cycle(0, 2, 3, 1, 1, 9, 0, 0, 0, 0, 0, 14);
    cycle(0, 1, 7, 1, 0, 0, 6, 0, 0, 0, 0, 14);
    cycle(0, 3, 8, 1, 1, 0, 0, 0, 0, 0, 0, 14);
    check("trap_after_stall", 32'(trap), 32'd1);
    cycle(0, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 4);

    // Same-cycle write uses the old entry; new entry visible next cycle.
    cycle(0, 2, 0, 0, 0, 3, 0, 1, 1, 3, 20, 12);
    cycle(0, 2, 0, 0, 0, 3, 0, 0, 0, 0, 0, 20);

    // Reset wins over a write; later dispatch to that entry traps.
    cycle(1, 0, 0, 0, 0, 0, 0, 1, 1, 7, 3, 0);
    check("trap_reset", 32'(trap), 32'd0);
    cycle(0, 2, 0, 0, 0, 7, 0, 0, 0, 0, 0, 31);
    check("trap_after_reset_write", 32'(trap), 32'd1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 3), $urandom_range(0, 31),
            $urandom_range(0, 4) == 0, $urandom_range(0, 1), $urandom_range(0, 15),
            $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 1),
            $urandom_range(0, 15), $urandom_range(0, 31), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
